// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
//   state_t         FSM state encoding (4 bits; the top zero-extends to STATE_W)
//   OP_*            instruction[31:26] opcodes recognised in DECODE
//   FN_*            instruction[5:0] R-type function codes
//   ALU_*           alucontrol encodings driven to the datapath ALU
//   ALUOP_*         2-bit operation class passed from the FSM to mc_aludec
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: ALU operation decoder.
//   aluop      in  2  operation class from the FSM (add / subtract / by funct)
//   funct      in  6  instruction[5:0]
//   alucontrol out 3  ALU operation; unknown funct codes fall back to add
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for a multicycle MIPS-style datapath.
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op, funct           instruction[31:26] and instruction[5:0]
//   zero                ALU zero flag (used in BRANCH)
//   mem_ready           memory completes this cycle (FETCH, MEMRD, MEMWR only)
//   pcen..regdst        1-bit datapath enables and selects
//   alusrcb, pcsrc      ALU B-operand select, next-PC select
//   alucontrol          ALU operation (from mc_aludec)
//   illegal_op          one-cycle pulse in DECODE for an undecodable opcode
//   state               current state, zero-extended to STATE_W for debug
// Build option: define MC_BNE_EN to execute op 000101 (bne) through BRANCH
// with the branch taken on !zero; otherwise that opcode is illegal.
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d;
  logic       op_illegal;
  logic       pc_write;
  logic       branch;
  logic       branch_taken;
  logic [1:0] aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = STATE_W'(state_q);

  always_comb begin
    state_d    = state_q;
    op_illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

`ifdef MC_BNE_EN
  assign branch_taken = (op == OP_BNE) ? ~zero : zero;
`else
  assign branch_taken = zero;
`endif

  always_comb begin
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    illegal_op = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb  = 2'b01;
        irwrite  = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = op_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_BRANCH: begin
        aluop  = ALUOP_SUB;
        pcsrc  = 2'b01;
        branch = 1'b1;
      end
      S_JUMP: begin
        pcsrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    // Reset forces FETCH, but FETCH decodes irwrite/pc-write from mem_ready;
    // keep every write enable quiet for as long as reset is held.
    if (reset) begin
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
    end
    pcen = pc_write | (branch & branch_taken);
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed, table-driven bench for mc_controller.
// Each table row holds one cycle's inputs plus the state and output bundle
// expected during that cycle; rows are applied after a rising edge and
// checked on the following falling edge. Reset-in-stall is hand-written.
// Honours MC_BNE_EN the same way as the design.
module tb_mc_controller;
  import mc_pkg::*;

  localparam int STATE_W = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [5:0]         op = 6'd0;
  logic [5:0]         funct = 6'd0;
  logic               zero = 1'b0;
  logic               mem_ready = 1'b1;
  logic               pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]         alusrcb, pcsrc;
  logic [2:0]         alucontrol;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  mc_controller #(.STATE_W(STATE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Bundle order: {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,
  //                alusrcb,pcsrc,alucontrol,illegal_op}
  logic [15:0] act_ctl;
  assign act_ctl = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                    alusrcb, pcsrc, alucontrol, illegal_op};

  localparam logic [15:0] E_RST  = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_F0   = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_F1   = {8'b1010_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_DEC  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_ILL  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [15:0] E_ADR  = {8'b0000_1000, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MRD  = {8'b0000_0100, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MWB  = {8'b0001_0010, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MWR  = {8'b0100_0100, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_AWB  = {8'b0001_0001, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_IWB  = {8'b0001_0000, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_BR1  = {8'b1000_0000, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [15:0] E_BR0  = {8'b0000_0000, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [15:0] E_JMP  = {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};
  localparam logic [15:0] E_XSLT = {8'b0000_1000, 2'b00, 2'b00, 3'b111, 1'b0};
  localparam logic [15:0] E_XSUB = {8'b0000_1000, 2'b00, 2'b00, 3'b110, 1'b0};
  localparam logic [15:0] E_XAND = {8'b0000_1000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [15:0] E_XOR  = {8'b0000_1000, 2'b00, 2'b00, 3'b001, 1'b0};
  localparam logic [15:0] E_XADD = {8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mrdy;
    state_t      st;
    logic [15:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic m, input state_t s, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.mrdy = m; v.st = s; v.ctl = c;
    vecs.push_back(v);
  endtask

  // One R-type instruction: fetch, decode, execute, write-back.
  task automatic add_rtype(input logic [5:0] f, input logic [15:0] ex);
    add(0, OP_RTYPE, f, 0, 1, S_FETCH,   E_F1);
    add(0, OP_RTYPE, f, 0, 0, S_DECODE,  E_DEC);
    add(0, OP_RTYPE, f, 0, 0, S_EXECUTE, ex);
    add(0, OP_RTYPE, f, 0, 1, S_ALUWB,   E_AWB);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;

    // Reset held with mem_ready high, then release and a stalled fetch.
    add(1, OP_LW, 0, 0, 1, S_FETCH,  E_RST);
    add(0, OP_LW, 0, 0, 0, S_FETCH,  E_F0);
    // lw with one MEMRD stall cycle; mem_ready ignored in DECODE/MEMADR.
    add(0, OP_LW, 0, 0, 1, S_FETCH,  E_F1);
    add(0, OP_LW, 0, 0, 1, S_DECODE, E_DEC);
    add(0, OP_LW, 0, 0, 0, S_MEMADR, E_ADR);
    add(0, OP_LW, 0, 0, 0, S_MEMRD,  E_MRD);
    add(0, OP_LW, 0, 0, 1, S_MEMRD,  E_MRD);
    add(0, OP_LW, 0, 0, 0, S_MEMWB,  E_MWB);
    // sw with three stall cycles: memwrite held for four cycles.
    add(0, OP_SW, 0, 0, 1, S_FETCH,  E_F1);
    add(0, OP_SW, 0, 0, 0, S_DECODE, E_DEC);
    add(0, OP_SW, 0, 0, 1, S_MEMADR, E_ADR);
    add(0, OP_SW, 0, 0, 0, S_MEMWR,  E_MWR);
    add(0, OP_SW, 0, 0, 0, S_MEMWR,  E_MWR);
    add(0, OP_SW, 0, 0, 0, S_MEMWR,  E_MWR);
    add(0, OP_SW, 0, 0, 1, S_MEMWR,  E_MWR);
    // beq taken, then not taken.
    add(0, OP_BEQ, 0, 1, 1, S_FETCH,  E_F1);
    add(0, OP_BEQ, 0, 1, 0, S_DECODE, E_DEC);
    add(0, OP_BEQ, 0, 1, 0, S_BRANCH, E_BR1);
    add(0, OP_BEQ, 0, 0, 1, S_FETCH,  E_F1);
    add(0, OP_BEQ, 0, 0, 0, S_DECODE, E_DEC);
    add(0, OP_BEQ, 0, 0, 0, S_BRANCH, E_BR0);
    // R-type function decode, including an unknown funct.
    add_rtype(FN_SLT, E_XSLT);
    add_rtype(FN_SUB, E_XSUB);
    add_rtype(FN_AND, E_XAND);
    add_rtype(FN_OR,  E_XOR);
    add_rtype(6'b000111, E_XADD);
    // Illegal opcode: one DECODE cycle with the pulse, straight back to FETCH.
    add(0, 6'b111111, 0, 0, 1, S_FETCH,  E_F1);
    add(0, 6'b111111, 0, 0, 1, S_DECODE, E_ILL);
    // addi and j.
    add(0, OP_ADDI, 0, 0, 1, S_FETCH,  E_F1);
    add(0, OP_ADDI, 0, 0, 0, S_DECODE, E_DEC);
    add(0, OP_ADDI, 0, 0, 0, S_ADDIEX, E_ADR);
    add(0, OP_ADDI, 0, 0, 0, S_ADDIWB, E_IWB);
    add(0, OP_J,    0, 0, 1, S_FETCH,  E_F1);
    add(0, OP_J,    0, 0, 0, S_DECODE, E_DEC);
    add(0, OP_J,    0, 0, 0, S_JUMP,   E_JMP);
    // bne with zero=0: taken when enabled, illegal otherwise.
    add(0, OP_BNE, 0, 0, 1, S_FETCH,  E_F1);
`ifdef MC_BNE_EN
    add(0, OP_BNE, 0, 0, 0, S_DECODE, E_DEC);
    add(0, OP_BNE, 0, 0, 0, S_BRANCH, E_BR1);
    add(0, OP_BNE, 0, 1, 1, S_FETCH,  E_F1);
    add(0, OP_BNE, 0, 1, 0, S_DECODE, E_DEC);
    add(0, OP_BNE, 0, 1, 0, S_BRANCH, E_BR0);
`else
    add(0, OP_BNE, 0, 0, 1, S_DECODE, E_ILL);
`endif
    add(0, OP_LW, 0, 0, 0, S_FETCH, E_F0);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      op        = vecs[i].op;
      funct     = vecs[i].funct;
      zero      = vecs[i].zero;
      mem_ready = vecs[i].mrdy;
      @(negedge clk);
      chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("row%0d ctl", i), 32'(act_ctl), 32'(vecs[i].ctl));
      @(posedge clk);
      #1;
    end

    // Reset during a MEMRD stall: state and enables drop without a clock edge.
    op = OP_LW; mem_ready = 1'b1;
    @(posedge clk); #1;             // DECODE
    mem_ready = 1'b0;
    @(posedge clk); #1;             // MEMADR
    @(posedge clk); #1;             // MEMRD
    @(posedge clk); #1;             // MEMRD, stalled
    chk("stall state", 32'(state), 32'(S_MEMRD));
    #2;
    e0 = edges;
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("async rst state", 32'(state), 32'(S_FETCH));
    chk("async rst ctl", 32'(act_ctl), 32'(E_RST));
    chk("async rst no edge", edges, e0);
    @(posedge clk); @(negedge clk);
    chk("held rst ctl", 32'(act_ctl), 32'(E_RST));
    chk("held rst state", 32'(state), 32'(S_FETCH));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("release fetch ctl", 32'(act_ctl), 32'(E_F1));
    @(posedge clk); #1;
    chk("release decode", 32'(state), 32'(S_DECODE));

    // Reset during a MEMWR stall abandons the store.
    op = OP_SW; mem_ready = 1'b0;
    @(posedge clk); #1;             // MEMADR
    @(posedge clk); #1;             // MEMWR
    chk("sw stall memwrite", 32'(memwrite), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("sw rst memwrite", 32'(memwrite), 32'd0);
    chk("sw rst state", 32'(state), 32'(S_FETCH));
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("sw resume decode", 32'(state), 32'(S_DECODE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter STATE_W, default 4, state-register width (min 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op  input  6  instruction[31:26] from instruction register.
REQ-005 SHALL have port funct  input  6  instruction[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-008 SHALL have outputs pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst  output  1 each  datapath enables and selects.
REQ-009 SHALL have outputs alusrcb, pcsrc  output  2 each  ALU B-operand select, next-PC select.
REQ-010 SHALL have output alucontrol  output  3  ALU operation.
REQ-011 SHALL have output illegal_op  output  1  one-cycle pulse on undecodable opcode.
REQ-012 SHALL have output state  output  STATE_W  current FSM state, for debug.

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; outputs are registered-state decodes, with no output a function of op except alucontrol.
REQ-014 SHALL transition: FETCH->DECODE when mem_ready, else hold; DECODE->by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH.
REQ-015 SHALL transition: MEMADR->MEMRD (op 100011) or MEMWR (op 101011); MEMRD->MEMWB when mem_ready, else hold; MEMWR->FETCH when mem_ready, else hold; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-016 SHALL drive, in FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, irwrite=mem_ready, pc-write=mem_ready.
REQ-017 SHALL drive, in DECODE: alusrca=0, alusrcb=11, ALU add; in MEMADR and ADDIEX: alusrca=1, alusrcb=10, ALU add.
REQ-018 SHALL drive iord=1 in MEMRD and MEMWR, and memwrite=1 in every MEMWR cycle until mem_ready is sampled.
REQ-019 SHALL drive regwrite=1 with regdst=0/memtoreg=1 in MEMWB, regdst=1/memtoreg=0 in ALUWB, and regdst=0/memtoreg=0 in ADDIWB.
REQ-020 SHALL drive alusrca=1, alusrcb=00 with funct-decoded ALU op in EXECUTE, and subtract with pcsrc=01 in BRANCH; JUMP: pcsrc=10, pc-write=1.
REQ-021 SHALL compute pcen = pc-write OR (BRANCH AND zero).
REQ-022 SHALL decode funct for alucontrol: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; add=010, subtract=110.
REQ-023 SHALL deassert all unlisted 1-bit outputs and drive unlisted 2-bit selects to 00 in each state.
REQ-024 SHALL pulse illegal_op for exactly the one DECODE cycle that takes the other->FETCH branch; pcen stays 0 that cycle.
REQ-025 SHALL treat mem_ready as don't-care outside FETCH, MEMRD and MEMWR.

Reset
REQ-026 SHALL, while reset is high, force state=FETCH asynchronously, with registered state only.
REQ-027 SHALL, while reset is high, hold irwrite, pcen, memwrite, regwrite and illegal_op at 0 regardless of mem_ready.
REQ-028 SHALL, on reset asserted mid-instruction (e.g. during MEMWR stall), abandon the instruction and, after release, resume in FETCH on the first rising edge.

Configuration
REQ-029 SHALL, with MC_BNE_EN defined, decode op 000101 to BRANCH with pcen = NOT zero in that state.
REQ-030 SHALL, without MC_BNE_EN, treat op 000101 as illegal per REQ-024.

Structure
REQ-031 SHALL place state enumeration, opcode constants, funct constants and alucontrol encodings in shared package mc_pkg.
REQ-032 SHALL contain funct/ALU-op decode in sub-module mc_aludec (inputs: 2-bit aluop, funct; output: alucontrol), instantiated once.

Verification
REQ-033 SHALL test: reset, release, mem_ready=1 with op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1, memtoreg=1 only in MEMWB.
REQ-034 SHALL test: sw (op 101011) with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH.
REQ-035 SHALL test: beq (op 000100) with zero=1 -> pcen=1, pcsrc=01 in BRANCH; zero=0 -> pcen=0.
REQ-036 SHALL test: R-type with funct=101010 -> alucontrol=111 in EXECUTE, regwrite=1, regdst=1 in ALUWB.
REQ-037 SHALL test: op=111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH; op=000101 behaves per macro setting.
REQ-038 SHALL test: reset asserted in MEMRD stall -> outputs zero immediately, state=FETCH without a clock edge.
